// File: rtl/snake_core.sv
// Snake game engine: grid RAM holds cell types, a ring FIFO holds body positions.
// One logic read port (registered) plus a registered render port that never stalls the game FSM.
module snake_core #(
  parameter int COLS    = 25,
  parameter int ROWS    = 19,
  parameter int MAX_LEN = 64,
  parameter int SCORE_W = 12,
  parameter int WRAP    = 1,
  parameter int START_X = 1,
  parameter int START_Y = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_tick,
  input  logic                      i_dir_valid,
  input  logic [1:0]                i_dir_req,
  input  logic [9:0]                i_rnd,
  input  logic [4:0]                i_rd_x,
  input  logic [4:0]                i_rd_y,
  output logic [1:0]                o_rd_cell,
  output logic [SCORE_W-1:0]        o_score,
  output logic [SCORE_W-1:0]        o_hi_score,
  output logic [$clog2(MAX_LEN):0]  o_length,
  output logic                      o_busy,
  output logic                      o_game_over
);
  localparam int NCELL = COLS * ROWS;
  localparam int AW    = $clog2(NCELL);
  localparam int PW    = $clog2(MAX_LEN);
  localparam int LW    = PW + 1;
  localparam logic [4:0] XMAX = 5'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);
  localparam logic [1:0] C_NONE = 2'd0, C_BODY = 2'd1, C_BRICK = 2'd2, C_APPLE = 2'd3;

  typedef enum logic [3:0] {
    S_CLR, S_INIT, S_GEN, S_GCHK, S_IDLE, S_RD, S_CHK, S_TAIL, S_HEAD, S_OVER
  } state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_grid [0:NCELL-1];
  logic [9:0]        r_fifo [0:MAX_LEN-1];
  logic [1:0]        r_rda, r_rd_cell;
  logic [AW-1:0]     r_cnt, r_cand;
  logic [7:0]        r_fail;
  logic              r_scan, r_off, r_grow;
  logic [4:0]        r_head_x, r_head_y, r_nx, r_ny;
  logic [1:0]        r_mv_dir, r_pend_dir, r_last_dir;
  logic [PW-1:0]     r_wp, r_rp;
  logic [LW-1:0]     r_len;
  logic [SCORE_W-1:0] r_score, r_hi;

  logic          w_we, w_cand_ok, w_pop, w_off;
  logic [AW-1:0] w_waddr, w_raddr, w_cand_addr, w_new_addr, w_tail_addr;
  logic [1:0]    w_wdata;
  logic [4:0]    w_nx, w_ny;
  logic [9:0]    w_tail;

  function automatic logic [AW-1:0] f_addr(input logic [4:0] x, input logic [4:0] y);
    return AW'(int'(y) * COLS + int'(x));
  endfunction

  assign w_cand_ok   = (int'(i_rnd[4:0]) < COLS) && (int'(i_rnd[9:5]) < ROWS);
  assign w_cand_addr = f_addr(i_rnd[4:0], i_rnd[9:5]);
  assign w_new_addr  = f_addr(r_nx, r_ny);
  assign w_tail      = r_fifo[r_rp];
  assign w_tail_addr = f_addr(w_tail[4:0], w_tail[9:5]);
  // A full snake always drops its tail, so eating at MAX_LEN keeps the length fixed.
  assign w_pop       = !r_grow || (r_len == LW'(MAX_LEN));

  always_comb begin
    w_nx  = r_head_x;
    w_ny  = r_head_y;
    w_off = 1'b0;
    case (r_pend_dir)
      2'd0: if (r_head_x == XMAX) begin w_nx = 5'd0; w_off = 1'b1; end else w_nx = r_head_x + 5'd1;
      2'd1: if (r_head_x == 5'd0) begin w_nx = XMAX; w_off = 1'b1; end else w_nx = r_head_x - 5'd1;
      2'd2: if (r_head_y == 5'd0) begin w_ny = YMAX; w_off = 1'b1; end else w_ny = r_head_y - 5'd1;
      default: if (r_head_y == YMAX) begin w_ny = 5'd0; w_off = 1'b1; end else w_ny = r_head_y + 5'd1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_CLR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = r_cnt;
    w_wdata = C_NONE;
    w_raddr = r_cand;
    case (r_state)
      S_CLR: begin
        w_we = 1'b1;
        if (r_cnt == AW'(NCELL - 1)) w_next = S_INIT;
      end
      S_INIT: begin
        w_we    = 1'b1;
        w_waddr = f_addr(5'(START_X), 5'(START_Y));
        w_wdata = C_BODY;
        w_next  = S_GEN;
      end
      S_GEN: begin
        if (r_scan) begin
          w_raddr = r_cnt;
          w_next  = S_GCHK;
        end else if (w_cand_ok) begin
          w_raddr = w_cand_addr;
          w_next  = S_GCHK;
        end
      end
      S_GCHK: begin
        if (r_rda == C_NONE) begin
          w_we    = 1'b1;
          w_waddr = r_cand;
          w_wdata = C_APPLE;
          w_next  = S_IDLE;
        end else if (r_scan && r_cnt == AW'(NCELL - 1)) w_next = S_IDLE;
        else w_next = S_GEN;
      end
      S_IDLE: if (i_tick) w_next = S_RD;
      S_RD: begin
        if (r_off && WRAP == 0) w_next = S_OVER;
        else begin
          w_raddr = w_new_addr;
          w_next  = S_CHK;
        end
      end
      // The tail is still Body here, so running into it counts as a collision.
      S_CHK: w_next = (r_rda == C_BODY || r_rda == C_BRICK) ? S_OVER : S_TAIL;
      S_TAIL: begin
        if (w_pop) begin
          w_we    = 1'b1;
          w_waddr = w_tail_addr;
        end
        w_next = S_HEAD;
      end
      S_HEAD: begin
        w_we    = 1'b1;
        w_waddr = w_new_addr;
        w_wdata = C_BODY;
        w_next  = r_grow ? S_GEN : S_IDLE;
      end
      S_OVER:  w_next = S_CLR;
      default: w_next = S_CLR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_grid[w_waddr] <= w_wdata;
    r_rda <= r_grid[w_raddr];
    if (r_state == S_INIT) r_fifo[r_wp] <= {5'(START_Y), 5'(START_X)};
    if (r_state == S_HEAD) r_fifo[r_wp] <= {r_ny, r_nx};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_cell  <= C_NONE;
      r_cnt      <= '0;
      r_cand     <= '0;
      r_fail     <= '0;
      r_scan     <= 1'b0;
      r_off      <= 1'b0;
      r_grow     <= 1'b0;
      r_head_x   <= '0;
      r_head_y   <= '0;
      r_nx       <= '0;
      r_ny       <= '0;
      r_mv_dir   <= 2'd0;
      r_pend_dir <= 2'd0;
      r_last_dir <= 2'd0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_len      <= '0;
      r_score    <= '0;
      r_hi       <= '0;
    end else begin
      r_rd_cell <= (int'(i_rd_x) < COLS && int'(i_rd_y) < ROWS) ?
                   r_grid[f_addr(i_rd_x, i_rd_y)] : C_NONE;
      // Reversal is judged against the last executed move, so two quick turns cannot reverse.
      if (i_dir_valid && i_dir_req != (r_last_dir ^ 2'b01)) r_pend_dir <= i_dir_req;
      case (r_state)
        S_CLR: begin
          r_cnt   <= (r_cnt == AW'(NCELL - 1)) ? '0 : r_cnt + 1'b1;
          r_score <= '0;
          r_wp    <= '0;
          r_rp    <= '0;
          r_len   <= '0;
        end
        S_INIT: begin
          r_wp       <= r_wp + 1'b1;
          r_len      <= LW'(1);
          r_head_x   <= 5'(START_X);
          r_head_y   <= 5'(START_Y);
          r_pend_dir <= 2'd0;
          r_last_dir <= 2'd0;
          r_fail     <= '0;
          r_scan     <= 1'b0;
        end
        S_GEN: begin
          if (r_scan) r_cand <= r_cnt;
          else if (w_cand_ok) r_cand <= w_cand_addr;
          else if (r_fail == 8'hFF) begin r_scan <= 1'b1; r_cnt <= '0; end
          else r_fail <= r_fail + 8'd1;
        end
        S_GCHK: begin
          if (r_rda != C_NONE) begin
            if (r_scan) r_cnt <= r_cnt + 1'b1;
            else if (r_fail == 8'hFF) begin r_scan <= 1'b1; r_cnt <= '0; end
            else r_fail <= r_fail + 8'd1;
          end
        end
        S_IDLE: begin
          if (i_tick) begin
            r_mv_dir <= r_pend_dir;
            r_nx     <= w_nx;
            r_ny     <= w_ny;
            r_off    <= w_off;
          end
        end
        S_CHK: begin
          r_grow <= (r_rda == C_APPLE);
          if (r_rda == C_APPLE && r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
        end
        S_TAIL: begin
          if (w_pop) r_rp <= r_rp + 1'b1;
          else       r_len <= r_len + 1'b1;
        end
        S_HEAD: begin
          r_wp       <= r_wp + 1'b1;
          r_head_x   <= r_nx;
          r_head_y   <= r_ny;
          r_last_dir <= r_mv_dir;
          r_fail     <= '0;
          r_scan     <= 1'b0;
        end
        S_OVER: begin
          if (r_score > r_hi) r_hi <= r_score;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_rd_cell   = r_rd_cell;
  assign o_score     = r_score;
  assign o_hi_score  = r_hi;
  assign o_length    = r_len;
  assign o_busy      = (r_state != S_IDLE);
  assign o_game_over = (r_state == S_OVER);
endmodule

// File: tb/tb_snake_core.sv
// Directed bench: three engines share stimulus (wrap/64, no-wrap/64, wrap/4) and are checked
// against hand-derived cell contents, scores, lengths and game-over pulses.
module tb_snake_core;
  logic       clk, rst, tick, dir_valid;
  logic [1:0] dir_req;
  logic [9:0] rnd;
  logic [4:0] rd_x, rd_y;
  logic [1:0] rd_cell [3];
  logic [11:0] score [3];
  logic [11:0] hi [3];
  logic [6:0] len0, len1;
  logic [2:0] len2;
  logic       busy [3];
  logic       go [3];
  int         go_cnt [3];
  int         n_tests = 0, n_fail = 0;
  int         lat, napple;

  snake_core #(.WRAP(1), .MAX_LEN(64)) u0 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_dir_valid(dir_valid), .i_dir_req(dir_req),
    .i_rnd(rnd), .i_rd_x(rd_x), .i_rd_y(rd_y), .o_rd_cell(rd_cell[0]), .o_score(score[0]),
    .o_hi_score(hi[0]), .o_length(len0), .o_busy(busy[0]), .o_game_over(go[0]));
  snake_core #(.WRAP(0), .MAX_LEN(64)) u1 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_dir_valid(dir_valid), .i_dir_req(dir_req),
    .i_rnd(rnd), .i_rd_x(rd_x), .i_rd_y(rd_y), .o_rd_cell(rd_cell[1]), .o_score(score[1]),
    .o_hi_score(hi[1]), .o_length(len1), .o_busy(busy[1]), .o_game_over(go[1]));
  snake_core #(.WRAP(1), .MAX_LEN(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_dir_valid(dir_valid), .i_dir_req(dir_req),
    .i_rnd(rnd), .i_rd_x(rd_x), .i_rd_y(rd_y), .o_rd_cell(rd_cell[2]), .o_score(score[2]),
    .o_hi_score(hi[2]), .o_length(len2), .o_busy(busy[2]), .o_game_over(go[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      go_cnt[0] <= 0; go_cnt[1] <= 0; go_cnt[2] <= 0;
    end else begin
      if (go[0]) go_cnt[0] <= go_cnt[0] + 1;
      if (go[1]) go_cnt[1] <= go_cnt[1] + 1;
      if (go[2]) go_cnt[2] <= go_cnt[2] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] xy(input int x, input int y);
    logic [4:0] lx, ly;
    lx = 5'(x);
    ly = 5'(y);
    return {ly, lx};
  endfunction

  task automatic rd(input int x, input int y);
    rd_x = 5'(x);
    rd_y = 5'(y);
    @(negedge clk);
  endtask

  task automatic dir(input int d);
    dir_valid = 1'b1;
    dir_req   = 2'(d);
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while ((busy[0] || busy[2]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_tick(output int n);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n = 1;
    while ((busy[0] || busy[2]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("tick_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick = 1'b0; dir_valid = 1'b0; dir_req = 2'd0;
    rnd = xy(2, 2); rd_x = 5'd0; rd_y = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy[0], 1);
    chk("rst_score", score[0], 0);
    chk("rst_hi", hi[0], 0);
    chk("rst_len", len0, 0);
    chk("rst_go", go[0], 0);
    chk("rst_cell", rd_cell[0], 0);
    rst = 1'b0;
    wait_idle(lat);
    chk("init_len", len0, 1);
    chk("init_score", score[0], 0);
    rd(1, 2); chk("init_head", rd_cell[0], 1);
    rd(2, 2); chk("init_apple", rd_cell[0], 3);
    rd(25, 2); chk("rd_oob_x", rd_cell[0], 0);
    rd(1, 19); chk("rd_oob_y", rd_cell[0], 0);
    napple = 0;
    for (int y = 0; y < 19; y++)
      for (int x = 0; x < 25; x++) begin
        rd(x, y);
        if (rd_cell[0] == 2'd3) napple++;
      end
    chk("one_apple", napple, 1);

    // Five apples in a row along y=2; the last eat places the next apple at (10,10).
    for (int i = 0; i < 5; i++) begin
      rnd = (i < 4) ? xy(3 + i, 2) : xy(10, 10);
      do_tick(lat);
      if (i == 0) begin
        chk("eat1_score", score[0], 1);
        chk("eat1_len", len0, 2);
        rd(3, 2); chk("eat1_new_apple", rd_cell[0], 3);
        rd(2, 2); chk("eat1_head", rd_cell[0], 1);
      end
    end
    chk("eat5_score0", score[0], 5);
    chk("eat5_len0", len0, 6);
    chk("eat5_score2", score[2], 5);
    chk("eat5_len2", len2, 4);
    rd(2, 2); chk("eat5_tail2", rd_cell[2], 0);
    chk("eat5_body0", rd_cell[0], 1);
    rd(10, 10); chk("eat5_apple", rd_cell[0], 3);

    // Left while heading Right is ignored; plain move with latency check.
    dir(1);
    do_tick(lat);
    chk("move_latency", lat, 5);
    rd(7, 2); chk("move_head0", rd_cell[0], 1);
    chk("move_head2", rd_cell[2], 1);
    rd(1, 2); chk("move_tail0", rd_cell[0], 0);
    rd(3, 2); chk("move_tail2", rd_cell[2], 0);
    chk("move_len0", len0, 6);
    chk("move_len2", len2, 4);
    chk("move_score0", score[0], 5);
    chk("left_no_go", go_cnt[0], 0);

    // Up then Left before one tick: Up taken, Left still a reversal of the last move.
    dir(2);
    dir(1);
    do_tick(lat);
    rd(7, 1); chk("up_head", rd_cell[0], 1);
    chk("up_no_go", go_cnt[0], 0);

    dir(0);
    for (int i = 0; i < 17; i++) do_tick(lat);
    rd(24, 1); chk("edge_head0", rd_cell[0], 1);
    chk("edge_head1", rd_cell[1], 1);
    do_tick(lat);
    rd(0, 1); chk("wrap_head0", rd_cell[0], 1);
    chk("wrap_head2", rd_cell[2], 1);
    chk("wrap_no_go0", go_cnt[0], 0);
    chk("nowrap_go1", go_cnt[1], 1);
    chk("nowrap_score1", score[1], 0);
    chk("nowrap_hi1", hi[1], 5);

    // Down, Left (wrap), Up lands on the body (the tail, for the 4-long snake).
    dir(3); do_tick(lat);
    dir(1); do_tick(lat);
    rd(24, 2); chk("loop_head2", rd_cell[2], 1);
    chk("loop_no_go2", go_cnt[2], 0);
    dir(2); do_tick(lat);
    chk("self_go0", go_cnt[0], 1);
    chk("self_go2", go_cnt[2], 1);
    chk("self_hi0", hi[0], 5);
    chk("self_hi2", hi[2], 5);
    chk("self_score2", score[2], 0);
    chk("self_score0", score[0], 0);
    chk("restart_len2", len2, 1);
    chk("restart_len0", len0, 1);
    rd(1, 2); chk("restart_head2", rd_cell[2], 1);
    chk("final_go1", go_cnt[1], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
